// File: rtl/compute_unit_sched_if.sv
// Bundle of request, compute-unit and response signals for compute_unit_sched.
// master is the scheduler's view, slave is the lanes/compute-unit view.
interface compute_unit_sched_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]      req_valid;
    logic [4*DW-1:0] req_dat1;
    logic [4*DW-1:0] req_dat2;
    logic [3:0]      req_ready;

    logic [DW-1:0]   cu_idat1;
    logic [DW-1:0]   cu_idat2;
    logic            cu_idatwr;
    logic            cu_inrdy;

    logic [DW-1:0]   cu_odat1;
    logic [DW-1:0]   cu_odat2;
    logic            cu_odatrd;
    logic            cu_outrdy;

    logic [3:0]      rsp_valid;
    logic [DW-1:0]   rsp_dat1;
    logic [DW-1:0]   rsp_dat2;
    logic [3:0]      rsp_ready;

    logic [CW-1:0]   outstanding;
    logic            err_orphan;

    modport master (
        input  req_valid, req_dat1, req_dat2,
        input  cu_inrdy, cu_odat1, cu_odat2, cu_outrdy,
        input  rsp_ready,
        output req_ready,
        output cu_idat1, cu_idat2, cu_idatwr, cu_odatrd,
        output rsp_valid, rsp_dat1, rsp_dat2,
        output outstanding, err_orphan
    );

    modport slave (
        output req_valid, req_dat1, req_dat2,
        output cu_inrdy, cu_odat1, cu_odat2, cu_outrdy,
        output rsp_ready,
        input  req_ready,
        input  cu_idat1, cu_idat2, cu_idatwr, cu_odatrd,
        input  rsp_valid, rsp_dat1, rsp_dat2,
        input  outstanding, err_orphan
    );
endinterface

// File: rtl/compute_unit_sched.sv
// Round-robin sharing of one compute unit among four lanes, with an
// in-order tag FIFO routing each result back through a one-entry response.
module compute_unit_sched #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    compute_unit_sched_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    last_grant;
    logic [1:0]    win;
    logic          found;
    logic          can_issue;
    logic          issue;

    logic [1:0]    tag_mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          tag_nonempty;

    logic          rsp_full;
    logic [1:0]    rsp_tag;
    logic [DW-1:0] rsp_d1;
    logic [DW-1:0] rsp_d2;
    logic          rsp_taken;
    logic          pop;

    logic [CW-1:0] cnt;
    logic          orphan;

    assign can_issue = bus.cu_inrdy & (cnt < CW'(DEPTH));

    // Pick the first valid lane starting one past the previous winner.
    always_comb begin
        win   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && bus.req_valid[last_grant + 2'(k)]) begin
                win   = last_grant + 2'(k);
                found = 1'b1;
            end
        end
    end

    // Reset must force the combinational strobes low immediately.
    assign issue         = ~rst & can_issue & found;
    assign bus.req_ready = issue ? (4'b0001 << win) : 4'b0000;
    assign bus.cu_idatwr = issue;
    assign bus.cu_idat1  = bus.req_dat1[32'(win)*DW +: DW];
    assign bus.cu_idat2  = bus.req_dat2[32'(win)*DW +: DW];

    assign tag_nonempty  = (wr_ptr != rd_ptr);
    assign rsp_taken     = rsp_full & bus.rsp_ready[rsp_tag];
    assign pop           = ~rst & bus.cu_outrdy & tag_nonempty
                         & (~rsp_full | rsp_taken);
    assign bus.cu_odatrd = pop;

    assign bus.rsp_valid   = rsp_full ? (4'b0001 << rsp_tag) : 4'b0000;
    assign bus.rsp_dat1    = rsp_d1;
    assign bus.rsp_dat2    = rsp_d2;
    assign bus.outstanding = cnt;
    assign bus.err_orphan  = orphan;

    // Tag storage; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr[AW-1:0]] <= win;
        end
    end

    // Grant pointer, tag FIFO pointers and outstanding count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 2'd3;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
        end else begin
            if (issue) begin
                last_grant <= win;
                wr_ptr     <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (issue & ~rsp_taken) begin
                cnt <= cnt + CW'(1);
            end else if (~issue & rsp_taken) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Response register, refilled on the same edge it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_full <= 1'b0;
            rsp_tag  <= 2'd0;
            rsp_d1   <= '0;
            rsp_d2   <= '0;
        end else if (pop) begin
            rsp_full <= 1'b1;
            rsp_tag  <= tag_mem[rd_ptr[AW-1:0]];
            rsp_d1   <= bus.cu_odat1;
            rsp_d2   <= bus.cu_odat2;
        end else if (rsp_taken) begin
            rsp_full <= 1'b0;
        end
    end

    // Sticky flag for a result arriving with no tag to route it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orphan <= 1'b0;
        end else if (bus.cu_outrdy & ~tag_nonempty) begin
            orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_compute_unit_sched.sv
// Bench for compute_unit_sched: vector table, directed corner cases and
// random traffic checked against an in-order queue model of the scheduler.
module tb_compute_unit_sched;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    compute_unit_sched_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    compute_unit_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            lane;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    typedef struct {
        logic [3:0] v;
        logic       ir;
        logic [3:0] er;
        int         eo;
    } vec_t;

    logic [3:0]    vld, rrdy;
    logic          inrdy, out_en, force_rdy;
    logic [DW-1:0] d1 [4];
    logic [DW-1:0] d2 [4];

    op_t expq[$];
    op_t cuq[$];
    int  m_last;
    int  pu;
    bit  m_orph;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]    s_ready, s_rspv;
    logic          s_wr, s_rd;
    logic [DW-1:0] s_i1, s_i2, s_r1, s_r2;
    logic [CW-1:0] s_out;

    vec_t tbl [11];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            bus.req_dat1[i*DW +: DW] = d1[i];
            bus.req_dat2[i*DW +: DW] = d2[i];
        end
        bus.req_valid = vld;
        bus.cu_inrdy  = inrdy;
        bus.rsp_ready = rrdy;
        bus.cu_outrdy = force_rdy | (out_en & (cuq.size() > 0));
        bus.cu_odat1  = (cuq.size() > 0) ? cuq[0].a : '0;
        bus.cu_odat2  = (cuq.size() > 0) ? cuq[0].b : '0;
    endtask

    // One clock: drive, check against the model at negedge, advance model.
    task automatic tick();
        int  win;
        int  pend;
        bit  full, taken, erd;
        logic [3:0] er;
        apply();
        @(negedge clk);
        s_ready = bus.req_ready;
        s_wr    = bus.cu_idatwr;
        s_i1    = bus.cu_idat1;
        s_i2    = bus.cu_idat2;
        s_rd    = bus.cu_odatrd;
        s_rspv  = bus.rsp_valid;
        s_r1    = bus.rsp_dat1;
        s_r2    = bus.rsp_dat2;
        win = -1;
        if (inrdy && expq.size() < DEPTH) begin
            for (int k = 1; k <= 4; k++) begin
                if (win < 0 && vld[(m_last + k) % 4]) win = (m_last + k) % 4;
            end
        end
        er    = (win >= 0) ? 4'(1 << win) : 4'h0;
        full  = (pu == 1);
        taken = full && rrdy[expq[0].lane];
        pend  = expq.size() - pu;
        erd   = bus.cu_outrdy && pend > 0 && (!full || taken);
        chk("req_ready", 64'(s_ready), 64'(er));
        chk("cu_idatwr", 64'(s_wr), 64'(win >= 0));
        if (win >= 0) begin
            chk("cu_idat1", 64'(s_i1), 64'(d1[win]));
            chk("cu_idat2", 64'(s_i2), 64'(d2[win]));
        end
        chk("cu_odatrd", 64'(s_rd), 64'(erd));
        chk("rsp_valid", 64'(s_rspv),
            full ? 64'(1 << expq[0].lane) : 64'(0));
        if (full) begin
            chk("rsp_dat1", 64'(s_r1), 64'(expq[0].a));
            chk("rsp_dat2", 64'(s_r2), 64'(expq[0].b));
        end
        chk("outstanding", 64'(bus.outstanding), 64'(expq.size()));
        chk("err_orphan", 64'(bus.err_orphan), 64'(m_orph));
        @(posedge clk);
        if (taken) begin
            void'(expq.pop_front());
            pu = 0;
        end
        if (erd) begin
            void'(cuq.pop_front());
            pu = 1;
        end
        if (win >= 0) begin
            expq.push_back('{win, d1[win], d2[win]});
            cuq.push_back('{win, d1[win], d2[win]});
            m_last = win;
        end
        if (bus.cu_outrdy && pend == 0) m_orph = 1;
        #1;
        s_out = bus.outstanding;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = '0;
        rrdy = '0;
        inrdy = 1'b0;
        out_en = 1'b0;
        force_rdy = 1'b0;
        expq.delete();
        cuq.delete();
        pu = 0;
        m_last = 3;
        m_orph = 0;
        apply();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'hF, 1'b1, 4'h1, 1};
        tbl[1]  = '{4'hF, 1'b1, 4'h2, 2};
        tbl[2]  = '{4'hF, 1'b1, 4'h4, 3};
        tbl[3]  = '{4'hF, 1'b1, 4'h8, 4};
        tbl[4]  = '{4'hF, 1'b1, 4'h1, 5};
        tbl[5]  = '{4'hA, 1'b0, 4'h0, 5};
        tbl[6]  = '{4'hA, 1'b1, 4'h2, 6};
        tbl[7]  = '{4'hA, 1'b1, 4'h8, 7};
        tbl[8]  = '{4'h0, 1'b1, 4'h0, 7};
        tbl[9]  = '{4'h4, 1'b1, 4'h4, 8};
        tbl[10] = '{4'hF, 1'b1, 4'h0, 8};

        for (int i = 0; i < 4; i++) begin
            d1[i] = DW'(16'h1100 * (i + 1));
            d2[i] = ~d1[i];
        end
        pu = 0;
        m_last = 3;
        m_orph = 0;

        // Reset state with requests pending must show nothing granted.
        rst = 1'b1;
        vld = 4'hF;
        inrdy = 1'b1;
        rrdy = '0;
        out_en = 1'b0;
        force_rdy = 1'b0;
        apply();
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_idatwr", 64'(bus.cu_idatwr), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_dat1", 64'(bus.rsp_dat1), 64'(0));
        chk("rst_outstanding", 64'(bus.outstanding), 64'(0));
        chk("rst_err_orphan", 64'(bus.err_orphan), 64'(0));
        do_reset();

        // Fairness and fill-to-DEPTH vectors.
        inrdy = 1'b1;
        for (int i = 0; i < 11; i++) begin
            vld   = tbl[i].v;
            inrdy = tbl[i].ir;
            tick();
            chk("tbl_ready", 64'(s_ready), 64'(tbl[i].er));
            chk("tbl_out", 64'(s_out), 64'(tbl[i].eo));
            if (tbl[i].er != 4'h0) begin
                chk("tbl_idat1", 64'(s_i1), 64'(d1[$clog2(tbl[i].er)]));
            end
        end

        // Full stall relieved by one accepted response.
        vld = 4'hF;
        inrdy = 1'b1;
        out_en = 1'b1;
        rrdy = 4'h0;
        tick();
        chk("full_ready", 64'(s_ready), 64'(0));
        rrdy = 4'hF;
        tick();
        chk("full_out7", 64'(s_out), 64'(7));
        out_en = 1'b0;
        rrdy = 4'h0;
        tick();
        chk("full_regrant", 64'(s_ready), 64'(4'h8));
        chk("full_out8", 64'(s_out), 64'(8));
        vld = 4'h0;
        out_en = 1'b1;
        rrdy = 4'hF;
        for (int i = 0; i < 12; i++) tick();
        chk("drain_out", 64'(s_out), 64'(0));

        // Result routing to lane 2 then lane 0.
        do_reset();
        inrdy = 1'b1;
        d1[2] = 16'h0011;
        d2[2] = 16'h0022;
        d1[0] = 16'h0033;
        d2[0] = 16'h0044;
        vld = 4'h4;
        tick();
        vld = 4'h1;
        tick();
        vld = 4'h0;
        out_en = 1'b1;
        tick();
        tick();
        chk("route_v2", 64'(s_rspv), 64'(4'h4));
        chk("route_d1a", 64'(s_r1), 64'(16'h0011));
        chk("route_d2a", 64'(s_r2), 64'(16'h0022));
        rrdy = 4'h4;
        tick();
        tick();
        chk("route_v0", 64'(s_rspv), 64'(4'h1));
        chk("route_d1b", 64'(s_r1), 64'(16'h0033));
        chk("route_d2b", 64'(s_r2), 64'(16'h0044));
        rrdy = 4'h1;
        tick();
        chk("route_out", 64'(s_out), 64'(0));

        // Head-of-line block on lane 1, then streaming resumes.
        do_reset();
        inrdy = 1'b1;
        out_en = 1'b1;
        rrdy = 4'b1101;
        vld = 4'h2;
        tick();
        vld = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        vld = 4'h0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("hol_rd", 64'(s_rd), 64'(0));
            chk("hol_v1", 64'(s_rspv), 64'(4'h2));
        end
        rrdy = 4'hF;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("hol_stream", 64'(s_rspv != 4'h0), 64'(1));
            if (j < 3) chk("hol_rd_go", 64'(s_rd), 64'(1));
        end
        tick();
        chk("hol_out", 64'(s_out), 64'(0));

        // Orphan result is flagged and sticks until reset.
        do_reset();
        force_rdy = 1'b1;
        tick();
        chk("orph_rd", 64'(s_rd), 64'(0));
        chk("orph_set", 64'(bus.err_orphan), 64'(1));
        force_rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("orph_sticky", 64'(bus.err_orphan), 64'(1));
        do_reset();
        chk("orph_clear", 64'(bus.err_orphan), 64'(0));

        // Asynchronous reset with three outstanding and a held response.
        inrdy = 1'b1;
        vld = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        vld = 4'h0;
        out_en = 1'b1;
        tick();
        tick();
        vld = 4'hF;
        apply();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", 64'(bus.req_ready), 64'(0));
        chk("arst_wr", 64'(bus.cu_idatwr), 64'(0));
        chk("arst_rd", 64'(bus.cu_odatrd), 64'(0));
        chk("arst_rspv", 64'(bus.rsp_valid), 64'(0));
        chk("arst_dat1", 64'(bus.rsp_dat1), 64'(0));
        chk("arst_dat2", 64'(bus.rsp_dat2), 64'(0));
        chk("arst_out", 64'(bus.outstanding), 64'(0));
        do_reset();
        inrdy = 1'b1;
        vld = 4'hF;
        tick();
        chk("arst_first", 64'(s_ready), 64'(4'h1));
        vld = 4'h0;
        out_en = 1'b1;
        rrdy = 4'hF;
        for (int i = 0; i < 4; i++) tick();

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            vld    = 4'($urandom);
            inrdy  = ($urandom % 4) != 0;
            out_en = ($urandom % 10) < 7;
            for (int i = 0; i < 4; i++) begin
                rrdy[i] = ($urandom % 5) != 0;
                d1[i]   = DW'($urandom);
                d2[i]   = DW'($urandom);
            end
            tick();
        end
        vld = 4'h0;
        out_en = 1'b1;
        rrdy = 4'hF;
        for (int i = 0; i < 12; i++) tick();
        chk("rand_drain", 64'(s_out), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/compute_unit_sched.md
# compute_unit_sched

Round-robin scheduler that shares one `compute_unit` (two-operand compute core fed and drained through FIFOs) among four requester lanes, e.g. NTT/butterfly sequencers. It picks one requester per cycle and writes its operand pair into the unit. It records the requester ID in an in-order tag FIFO, pops results when the unit has them, and routes each result back to the originating lane through a one-entry response register with per-lane backpressure.

## Interface
- `DW`, 16: operand/result width per data word.
- `DEPTH`, 8: maximum outstanding operations, which is also the tag FIFO depth. Must be a power of two, ≥2.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  4  per-lane request valid.
- `req_dat1`  in  4*DW  lane i operand 1 at bits [i*DW +: DW].
- `req_dat2`  in  4*DW  lane i operand 2, same packing.
- `req_ready`  out  4  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `cu_idat1`  out  DW  operand 1 to the compute unit.
- `cu_idat2`  out  DW  operand 2 to the compute unit.
- `cu_idatwr`  out  1  write strobe to the compute unit input.
- `cu_inrdy`  in  1  compute unit can accept a write this cycle.
- `cu_odat1`  in  DW  result word 1, show-ahead, valid while `cu_outrdy`.
- `cu_odat2`  in  DW  result word 2.
- `cu_odatrd`  out  1  pop strobe to the compute unit output.
- `cu_outrdy`  in  1  a result is available.
- `rsp_valid`  out  4  one-hot response valid.
- `rsp_dat1`  out  DW  response word 1, shared bus.
- `rsp_dat2`  out  DW  response word 2, shared bus.
- `rsp_ready`  in  4  per-lane response accept.
- `outstanding`  out  $clog2(DEPTH)+1  count of issued operations not yet accepted by a lane.
- `err_orphan`  out  1  sticky error flag: a result was seen with no tag pending.

## Operation
- **Issue condition.** `can_issue = cu_inrdy & (outstanding < DEPTH)`.
- **Arbitration.** Round-robin over `req_valid`, with priority starting at `last_grant+1` mod 4.
  - `req_ready` is one-hot to the winner when `can_issue`, otherwise 0.
  - `req_ready` may depend combinationally on `req_valid`, but a lane must not make `req_valid` depend on `req_ready`.
- **Issue.** On a handshake:
  - `cu_idatwr=1` in the same cycle (combinational), with `cu_idat1/2` muxed from the winning lane.
  - The winner index is pushed into the tag FIFO.
  - `last_grant` is updated to the winner.
  - `last_grant` is unchanged on cycles with no handshake.
- **Drain.** `cu_odatrd = cu_outrdy & tag_nonempty & (~rsp_full | rsp_taken)`, where `rsp_taken = |(rsp_valid & rsp_ready)`. On `cu_odatrd`:
  - `cu_odat1/2` are captured into the response register.
  - The tag FIFO is popped and the tag is stored with the data.
- **Response.** `rsp_valid[tag]=1` while the register is full. Data is held stable until `rsp_ready[tag]`; `rsp_ready` of other lanes is ignored.
- **Outstanding counter.** +1 on issue, −1 on `rsp_taken`, unchanged when both happen in the same cycle.
- **Orphan results.** `cu_outrdy` with an empty tag FIFO means no pop, and `err_orphan` is set until `rst`.

## Timing
- **Reset values.** Async `rst` clears:
  - `req_ready`, `cu_idatwr`, `cu_odatrd`, `rsp_valid`: 0
  - `rsp_dat1`, `rsp_dat2`: 0
  - `outstanding`: 0
  - `err_orphan`: 0
  - `last_grant`: 3, so lane 0 has first priority.
  - The tag FIFO is emptied.
- **Reset during operation.** Reset mid-operation discards all tags and any held response. There is no replay.
- **Issue latency.** 0 cycles, request handshake to `cu_idatwr`.
- **Response latency.** Response appears 1 cycle after `cu_odatrd`.
- **Throughput.** Sustained 1 issue and 1 response per cycle.
  - A full response register accepted this cycle is refilled on the same edge with no bubble.
- **Backpressure.**
  - `cu_inrdy=0` or `outstanding==DEPTH` forces all `req_ready` to 0.
  - A stalled lane (`rsp_ready=0`) blocks all responses, because ordering is strict in-order.
- **Counter and tag FIFO bounds.** `outstanding` never exceeds DEPTH. The tag FIFO pointers wrap mod DEPTH. The FIFO cannot overflow, since its occupancy ≤ `outstanding`.
- **Simultaneous push and pop.** A tag push and pop in the same cycle leave the occupancy unchanged, and this is legal even when occupancy is DEPTH−1 or 1.

## Test plan
- **Round-robin fairness.** All 4 lanes hold `req_valid`, `cu_inrdy=1`. Expected: grants 0,1,2,3,0 on consecutive cycles, and `cu_idat1` equals the granted lane's operand each cycle.
- **Result routing.** Issue lane 2 (0x0011/0x0022) then lane 0 (0x0033/0x0044); the model returns results in order. Expected: `rsp_valid=0100` with 0x0011/0x0022, then `rsp_valid=0001` with 0x0033/0x0044.
- **Full stall.** DEPTH=8, `cu_outrdy=0`, 8 issues. Expected: `outstanding=8` and `req_ready=0`. One result plus `rsp_ready` then gives `outstanding=7`, and one more grant is allowed.
- **Head-of-line block.** Lane 1's response is held with `rsp_ready[1]=0` for 5 cycles while `cu_outrdy=1`. Expected: `cu_odatrd=0` during the stall, and streaming resumes at 1/cycle after accept.
- **Orphan result.** Assert `cu_outrdy` with no issues. Expected: `cu_odatrd=0`, `err_orphan=1` next cycle, and it stays 1 until `rst`.
- **Reset mid-operation.** Assert `rst` asynchronously between edges with 3 outstanding. Expected: all outputs are 0 immediately, and after release lane 0 wins first.
